// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lsu_pkg
// Description : Shared size encodings, FSM states and mask/alignment helpers
//               for the load/store memory controller.
// Revision    : 1.0 - initial release
// ============================================================================
package lsu_pkg;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LD_WAIT = 2'd1,
        ST_RESP    = 2'd2
    } lsu_state_e;

    // Byte-enable mask for the memory, relative to the access address.
    function automatic logic [7:0] size_to_mask(input logic [1:0] size);
        logic [7:0] mask;
        case (size)
            SZ_B:    mask = 8'h01;
            SZ_H:    mask = 8'h03;
            SZ_W:    mask = 8'h0F;
            default: mask = 8'hFF;
        endcase
        return mask;
    endfunction

    function automatic logic is_aligned(input logic [1:0] size, input logic [2:0] addr_lo);
        logic ok;
        case (size)
            SZ_B:    ok = 1'b1;
            SZ_H:    ok = (addr_lo[0] == 1'b0);
            SZ_W:    ok = (addr_lo[1:0] == 2'b00);
            default: ok = (addr_lo == 3'b000);
        endcase
        return ok;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_load_ext.sv
`default_nettype none
// ============================================================================
// Module      : lsu_load_ext
// Description : Combinational zero/sign extension of right-justified load data.
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_load_ext
    import lsu_pkg::*;
(
    input  logic [63:0] raw,
    input  logic [1:0]  size,
    input  logic        is_signed,
    output logic [63:0] extended
);

    always_comb begin
        extended = raw;
        case (size)
            SZ_B: extended = is_signed ? {{56{raw[7]}},  raw[7:0]}  : {56'd0, raw[7:0]};
            SZ_H: extended = is_signed ? {{48{raw[15]}}, raw[15:0]} : {48'd0, raw[15:0]};
            SZ_W: extended = is_signed ? {{32{raw[31]}}, raw[31:0]} : {32'd0, raw[31:0]};
            default: extended = raw;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/lsu_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : lsu_mem_ctrl
// Description : Single-outstanding load/store controller in front of a
//               registered-read memory model, with alignment checking.
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_mem_ctrl
    import lsu_pkg::*;
#(
    parameter int XLEN        = 64,
    parameter bit CHECK_ALIGN = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [1:0]      req_size,
    input  logic            req_signed,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_rdata,
    output logic            resp_err,
    output logic            mem_rd_en,
    output logic [XLEN-1:0] mem_rd_addr,
    input  logic [XLEN-1:0] mem_rd_data,
    output logic            mem_we_en,
    output logic [XLEN-1:0] mem_we_addr,
    output logic [XLEN-1:0] mem_we_data,
    output logic [7:0]      mem_we_mask
);

    lsu_state_e      state_q, state_d;
    logic [XLEN-1:0] resp_rdata_q, resp_rdata_d;
    logic            resp_err_q, resp_err_d;
    logic [1:0]      ld_size_q, ld_size_d;
    logic            ld_signed_q, ld_signed_d;

    logic            w_acc;
    logic            w_misaligned;
    logic [XLEN-1:0] w_ext_data;

    // Gating with rst keeps the handshake and strobes quiet during reset.
    assign req_ready    = (state_q == ST_IDLE) & ~rst;
    assign w_acc        = req_valid & req_ready;
    assign w_misaligned = CHECK_ALIGN & ~is_aligned(req_size, req_addr[2:0]);

    assign mem_rd_en   = w_acc & ~req_we & ~w_misaligned;
    assign mem_we_en   = w_acc &  req_we & ~w_misaligned;
    assign mem_rd_addr = req_addr;
    assign mem_we_addr = req_addr;
    assign mem_we_data = req_wdata;
    assign mem_we_mask = size_to_mask(req_size);

    assign resp_valid = (state_q == ST_RESP);
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;

    lsu_load_ext u_load_ext (
        .raw       (mem_rd_data),
        .size      (ld_size_q),
        .is_signed (ld_signed_q),
        .extended  (w_ext_data)
    );

    always_comb begin
        state_d      = state_q;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        ld_size_d    = ld_size_q;
        ld_signed_d  = ld_signed_q;
        case (state_q)
            ST_IDLE: begin
                if (w_acc) begin
                    resp_rdata_d = '0;
                    resp_err_d   = w_misaligned;
                    if (w_misaligned || req_we) begin
                        state_d = ST_RESP;
                    end else begin
                        state_d     = ST_LD_WAIT;
                        ld_size_d   = req_size;
                        ld_signed_d = req_signed;
                    end
                end
            end
            ST_LD_WAIT: begin
                // Memory read data is registered: it is valid exactly now.
                resp_rdata_d = w_ext_data;
                resp_err_d   = 1'b0;
                state_d      = ST_RESP;
            end
            ST_RESP: begin
                if (resp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
            ld_size_q    <= SZ_B;
            ld_signed_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
            ld_size_q    <= ld_size_d;
            ld_signed_q  <= ld_signed_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lsu_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_lsu_mem_ctrl
// Description : Randomized self-checking bench for lsu_mem_ctrl with a
//               byte-addressed memory model and a request-level reference.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lsu_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_we, req_signed;
    logic [1:0]  req_size;
    logic [63:0] req_addr, req_wdata;
    logic        resp_valid, resp_ready, resp_err;
    logic [63:0] resp_rdata;
    logic        mem_rd_en, mem_we_en;
    logic [63:0] mem_rd_addr, mem_rd_data, mem_we_addr, mem_we_data;
    logic [7:0]  mem_we_mask;

    int total_cnt = 0;
    int bad_cnt   = 0;

    logic [7:0] mem_bytes [logic [63:0]];
    logic [7:0] ref_bytes [logic [63:0]];

    always #5 clk = ~clk;

    lsu_mem_ctrl #(.XLEN(64), .CHECK_ALIGN(1'b1)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_we      (req_we),
        .req_size    (req_size),
        .req_signed  (req_signed),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_rdata  (resp_rdata),
        .resp_err    (resp_err),
        .mem_rd_en   (mem_rd_en),
        .mem_rd_addr (mem_rd_addr),
        .mem_rd_data (mem_rd_data),
        .mem_we_en   (mem_we_en),
        .mem_we_addr (mem_we_addr),
        .mem_we_data (mem_we_data),
        .mem_we_mask (mem_we_mask)
    );

    function automatic logic [7:0] def_byte(input logic [63:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    // Memory model: byte writes under mask, registered 8-byte little-endian read.
    always @(posedge clk) begin
        if (mem_we_en) begin
            for (int i = 0; i < 8; i++)
                if (mem_we_mask[i]) mem_bytes[mem_we_addr + 64'(i)] = mem_we_data[8*i +: 8];
        end
        if (mem_rd_en) begin
            logic [63:0] v;
            for (int i = 0; i < 8; i++) begin
                logic [63:0] a;
                a = mem_rd_addr + 64'(i);
                v[8*i +: 8] = mem_bytes.exists(a) ? mem_bytes[a] : def_byte(a);
            end
            mem_rd_data <= v;
        end else begin
            mem_rd_data <= {$urandom, $urandom};
        end
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total_cnt++;
        if (got !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got=0x%016h expected=0x%016h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] ref_load(input logic [63:0] addr, input logic [1:0] size,
                                             input logic sgn);
        logic [63:0] raw;
        int nbytes;
        nbytes = 1 << size;
        raw = 64'd0;
        for (int i = 0; i < nbytes; i++) begin
            logic [63:0] a;
            a = addr + 64'(i);
            raw = raw + ((ref_bytes.exists(a) ? 64'(ref_bytes[a]) : 64'(def_byte(a))) << (8*i));
        end
        if (nbytes < 8 && sgn && raw[8*nbytes-1])
            raw = raw - (64'd1 << (8*nbytes));
        return raw;
    endfunction

    task automatic ref_store(input logic [63:0] addr, input logic [1:0] size, input logic [63:0] d);
        for (int i = 0; i < (1 << size); i++)
            ref_bytes[addr + 64'(i)] = d[8*i +: 8];
    endtask

    task automatic preload(input logic [63:0] addr, input logic [63:0] d);
        for (int i = 0; i < 8; i++) begin
            mem_bytes[addr + 64'(i)] = d[8*i +: 8];
            ref_bytes[addr + 64'(i)] = d[8*i +: 8];
        end
    endtask

    task automatic drive_junk();
        req_valid  = 1'b1;
        req_we     = 1'($urandom);
        req_size   = 2'($urandom);
        req_signed = 1'($urandom);
        req_addr   = 64'h8000_0000 + 64'($urandom_range(0, 63));
        req_wdata  = {$urandom, $urandom};
    endtask

    task automatic do_req(input logic we, input logic [1:0] size, input logic sgn,
                          input logic [63:0] addr, input logic [63:0] wdata, input int stall);
        logic        mis;
        logic [63:0] exp_data;
        logic [15:0] exp_mask;
        int          lat;
        mis      = (addr % (64'd1 << size)) != 64'd0;
        exp_data = 64'd0;
        exp_mask = (16'd1 << (1 << size)) - 16'd1;
        if (!mis && !we) exp_data = ref_load(addr, size, sgn);
        if (!mis && we)  ref_store(addr, size, wdata);

        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_size = size; req_signed = sgn;
        req_addr = addr; req_wdata = wdata; resp_ready = 1'b0;
        #1;
        check_val("req_ready_idle", 64'(req_ready), 64'd1);
        check_val("rd_en", 64'(mem_rd_en), 64'(!mis && !we));
        check_val("we_en", 64'(mem_we_en), 64'(!mis && we));
        if (!mis) begin
            check_val("rd_addr", mem_rd_addr, addr);
            check_val("we_addr", mem_we_addr, addr);
        end
        if (!mis && we) begin
            check_val("we_data", mem_we_data, wdata);
            check_val("we_mask", 64'(mem_we_mask), 64'(exp_mask));
        end

        @(negedge clk);
        drive_junk();
        #1;
        lat = 1;
        check_val("busy_rd_en", 64'(mem_rd_en), 64'd0);
        check_val("busy_we_en", 64'(mem_we_en), 64'd0);
        check_val("busy_req_ready", 64'(req_ready), 64'd0);
        while (!resp_valid && lat < 4) begin
            @(negedge clk);
            drive_junk();
            #1;
            lat++;
            check_val("busy_rd_en", 64'(mem_rd_en), 64'd0);
            check_val("busy_we_en", 64'(mem_we_en), 64'd0);
        end
        check_val("resp_valid", 64'(resp_valid), 64'd1);
        check_val("latency", 64'(lat), (we || mis) ? 64'd1 : 64'd2);
        check_val("resp_rdata", resp_rdata, exp_data);
        check_val("resp_err", 64'(resp_err), 64'(mis));

        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            drive_junk();
            #1;
            check_val("stall_valid", 64'(resp_valid), 64'd1);
            check_val("stall_rdata", resp_rdata, exp_data);
            check_val("stall_err", 64'(resp_err), 64'(mis));
            check_val("stall_req_ready", 64'(req_ready), 64'd0);
            check_val("stall_strobe", 64'(mem_rd_en | mem_we_en), 64'd0);
        end

        @(negedge clk);
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        #1;
        check_val("hs_valid", 64'(resp_valid), 64'd1);
        @(negedge clk);
        resp_ready = 1'b0;
        #1;
        check_val("post_valid", 64'(resp_valid), 64'd0);
        check_val("post_req_ready", 64'(req_ready), 64'd1);
    endtask

    initial begin
        rst = 1'b1; resp_ready = 1'b0;
        drive_junk();
        #1;
        check_val("rst_resp_valid", 64'(resp_valid), 64'd0);
        check_val("rst_resp_rdata", resp_rdata, 64'd0);
        check_val("rst_resp_err", 64'(resp_err), 64'd0);
        check_val("rst_req_ready", 64'(req_ready), 64'd0);
        check_val("rst_strobes", 64'(mem_rd_en | mem_we_en), 64'd0);
        repeat (3) @(negedge clk);
        req_valid = 1'b0;
        rst = 1'b0;

        preload(64'h8000_0000, 64'h1122_3344_5566_7788);
        preload(64'h8000_0010, 64'h0000_0000_0000_0080);
        do_req(1'b0, 2'd3, 1'b0, 64'h8000_0000, 64'd0, 0);
        check_val("dword_literal", resp_rdata, 64'h1122_3344_5566_7788);
        do_req(1'b0, 2'd0, 1'b1, 64'h8000_0010, 64'd0, 0);
        check_val("byte_signed_literal", resp_rdata, 64'hFFFF_FFFF_FFFF_FF80);
        do_req(1'b0, 2'd0, 1'b0, 64'h8000_0010, 64'd0, 1);
        check_val("byte_unsigned_literal", resp_rdata, 64'h0000_0000_0000_0080);
        do_req(1'b1, 2'd2, 1'b0, 64'h8000_0004, 64'hDEAD_BEEF, 0);
        do_req(1'b0, 2'd2, 1'b0, 64'h8000_0004, 64'd0, 0);
        check_val("word_readback", resp_rdata, 64'h0000_0000_DEAD_BEEF);
        do_req(1'b0, 2'd1, 1'b0, 64'h8000_0001, 64'd0, 0);
        check_val("misaligned_err", 64'(resp_err), 64'd1);
        do_req(1'b1, 2'd3, 1'b0, 64'h8000_0004, 64'h1234, 5);

        // Reset while a load is waiting for memory data.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'd3; req_signed = 1'b0;
        req_addr = 64'h8000_0008; resp_ready = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_val("midrst_valid", 64'(resp_valid), 64'd0);
        check_val("midrst_req_ready", 64'(req_ready), 64'd0);
        check_val("midrst_strobes", 64'(mem_rd_en | mem_we_en), 64'd0);
        repeat (2) @(negedge clk);
        req_valid = 1'b0; resp_ready = 1'b0;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            check_val("postrst_valid", 64'(resp_valid), 64'd0);
            check_val("postrst_req_ready", 64'(req_ready), 64'd1);
        end
        do_req(1'b0, 2'd3, 1'b0, 64'h8000_0008, 64'd0, 0);

        for (int n = 0; n < 300; n++) begin
            do_req(1'($urandom), 2'($urandom), 1'($urandom),
                   64'h8000_0000 + 64'($urandom_range(0, 63)),
                   {$urandom, $urandom}, int'($urandom_range(0, 3)));
        end

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
`default_nettype wire
